// File: rtl/exc_pkg.sv
// Shared definitions for the machine-mode exception unit: CSR addresses,
// trap cause codes, CSR write modes and FSM state encoding.
package exc_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [5:0] CAUSE_ILLEGAL     = 6'd2;
  localparam logic [5:0] CAUSE_ECALL_M     = 6'd11;
  localparam logic [5:0] CAUSE_LOAD_FAULT  = 6'd5;
  localparam logic [5:0] CAUSE_STORE_FAULT = 6'd7;
  localparam logic [5:0] CAUSE_IRQ_BASE    = 6'd16;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  typedef enum logic [1:0] {
    WSC_NONE  = 2'b00,
    WSC_WRITE = 2'b01,
    WSC_SET   = 2'b10,
    WSC_CLEAR = 2'b11
  } wsc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } exc_state_e;

endpackage

// File: rtl/csr_file_px.sv
// Machine-mode CSR storage with combinational read mux. Trap and mret
// updates take precedence over instruction writes.
module csr_file_px
  import exc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_we,
  input  logic [1:0]         csr_wsc_mode,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_operand,
  output logic [XLEN-1:0]    csr_r_data,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               trap_take,
  input  logic [XLEN-1:0]    trap_mepc,
  input  logic [XLEN-1:0]    trap_mcause,
  input  logic [XLEN-1:0]    trap_mtval,
  input  logic               mret_take,
  output logic               mstatus_mie,
  output logic [NUM_IRQ-1:0] mie_bits,
  output logic [XLEN-1:0]    mtvec,
  output logic [XLEN-1:0]    mepc
);

  logic               mie_reg, mpie_reg;
  logic [NUM_IRQ-1:0] mie_en_reg;
  logic [XLEN-1:0]    mtvec_reg, mepc_reg, mcause_reg, mtval_reg;
  logic [XLEN-1:0]    raw_rd, wr_value;

  always_comb begin
    raw_rd = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        raw_rd[MSTATUS_MIE_BIT]  = mie_reg;
        raw_rd[MSTATUS_MPIE_BIT] = mpie_reg;
      end
      CSR_MIE:    raw_rd[NUM_IRQ-1:0] = mie_en_reg;
      CSR_MTVEC:  raw_rd = mtvec_reg;
      CSR_MEPC:   raw_rd = mepc_reg;
      CSR_MCAUSE: raw_rd = mcause_reg;
      CSR_MTVAL:  raw_rd = mtval_reg;
      CSR_MIP:    raw_rd[NUM_IRQ-1:0] = irq;
      default:    raw_rd = '0;
    endcase
  end

  // mip follows irq directly, so the read port is masked during reset
  assign csr_r_data = rst ? raw_rd : '0;

  always_comb begin
    case (wsc_mode_e'(csr_wsc_mode))
      WSC_WRITE: wr_value = csr_operand;
      WSC_SET:   wr_value = raw_rd | csr_operand;
      WSC_CLEAR: wr_value = raw_rd & ~csr_operand;
      default:   wr_value = raw_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_reg    <= 1'b0;
      mpie_reg   <= 1'b0;
      mie_en_reg <= '0;
      mtvec_reg  <= '0;
      mepc_reg   <= '0;
      mcause_reg <= '0;
      mtval_reg  <= '0;
    end else if (trap_take) begin
      mepc_reg   <= trap_mepc;
      mcause_reg <= trap_mcause;
      mtval_reg  <= trap_mtval;
      mpie_reg   <= mie_reg;
      mie_reg    <= 1'b0;
    end else if (mret_take) begin
      mie_reg    <= mpie_reg;
      mpie_reg   <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_reg  <= wr_value[MSTATUS_MIE_BIT];
          mpie_reg <= wr_value[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    mie_en_reg <= wr_value[NUM_IRQ-1:0];
        CSR_MTVEC:  mtvec_reg  <= wr_value;
        CSR_MEPC:   mepc_reg   <= wr_value;
        CSR_MCAUSE: mcause_reg <= wr_value;
        CSR_MTVAL:  mtval_reg  <= wr_value;
        default: ;
      endcase
    end
  end

  assign mstatus_mie = mie_reg;
  assign mie_bits    = mie_en_reg;
  assign mtvec       = mtvec_reg;
  assign mepc        = mepc_reg;

endmodule

// File: rtl/exception_unit_px.sv
// Machine-mode trap controller: prioritises exceptions, mret and interrupts
// sampled in the MEM stage, redirects fetch and flushes the pipeline.
module exception_unit_px
  import exc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_IRQ     = 4,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_rw_in,
  input  logic [1:0]         csr_wsc_mode_in,
  input  logic               csr_w_imm_mux,
  input  logic [11:0]        csr_rw_addr_in,
  input  logic [XLEN-1:0]    csr_w_data_reg,
  input  logic [4:0]         csr_w_data_imm,
  output logic [XLEN-1:0]    csr_r_data_out,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               illegal_inst,
  input  logic               ecall_m,
  input  logic               l_access_fault,
  input  logic               s_access_fault,
  input  logic               mret,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  input  logic [XLEN-1:0]    fault_addr,
  output logic [XLEN-1:0]    PC_redirect,
  output logic               redirect_mux,
  output logic               reg_FD_flush,
  output logic               reg_DE_flush,
  output logic               reg_EM_flush,
  output logic               reg_MW_flush,
  output logic               RegWrite_cancel,
  output logic               trap_busy
);

  exc_state_e state_reg, state_next;

  logic               mstatus_mie;
  logic [NUM_IRQ-1:0] mie_bits, irq_pend;
  logic [XLEN-1:0]    mtvec, mepc, trap_base, csr_operand;
  logic [XLEN-1:0]    trap_mepc, trap_mcause, trap_mtval;
  logic               exc_valid, exc_has_tval, irq_valid;
  logic [5:0]         exc_cause, irq_cause;
  logic [3:0]         irq_idx;
  logic               trap_take, mret_take, csr_we;

  always_comb begin
    exc_valid    = 1'b1;
    exc_has_tval = 1'b0;
    exc_cause    = '0;
    if (illegal_inst)        exc_cause = CAUSE_ILLEGAL;
    else if (ecall_m)        exc_cause = CAUSE_ECALL_M;
    else if (l_access_fault) begin exc_cause = CAUSE_LOAD_FAULT;  exc_has_tval = 1'b1; end
    else if (s_access_fault) begin exc_cause = CAUSE_STORE_FAULT; exc_has_tval = 1'b1; end
    else                     exc_valid = 1'b0;
  end

  // Scan downward so the lowest pending index is the one left standing
  assign irq_pend = irq & mie_bits;
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_idx = 4'(i);
    end
  end
  assign irq_valid = mstatus_mie && (|irq_pend);
  assign irq_cause = CAUSE_IRQ_BASE + {2'b00, irq_idx};
  assign trap_base = {mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    state_next      = state_reg;
    trap_take       = 1'b0;
    mret_take       = 1'b0;
    trap_mepc       = '0;
    trap_mcause     = '0;
    trap_mtval      = '0;
    PC_redirect     = '0;
    redirect_mux    = 1'b0;
    reg_FD_flush    = 1'b0;
    reg_DE_flush    = 1'b0;
    reg_EM_flush    = 1'b0;
    reg_MW_flush    = 1'b0;
    RegWrite_cancel = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rst && exc_valid) begin
          state_next      = ST_TRAP;
          trap_take       = 1'b1;
          trap_mepc       = epc_cur;
          trap_mcause     = {{(XLEN-6){1'b0}}, exc_cause};
          trap_mtval      = exc_has_tval ? fault_addr : '0;
          PC_redirect     = trap_base;
          redirect_mux    = 1'b1;
          reg_FD_flush    = 1'b1;
          reg_DE_flush    = 1'b1;
          reg_EM_flush    = 1'b1;
          reg_MW_flush    = 1'b1;
          RegWrite_cancel = 1'b1;
        end else if (rst && mret) begin
          state_next   = ST_RET;
          mret_take    = 1'b1;
          PC_redirect  = mepc;
          redirect_mux = 1'b1;
          reg_FD_flush = 1'b1;
          reg_DE_flush = 1'b1;
        end else if (rst && irq_valid) begin
          state_next   = ST_TRAP;
          trap_take    = 1'b1;
          trap_mepc    = epc_next;
          trap_mcause  = {1'b1, {(XLEN-7){1'b0}}, irq_cause};
          PC_redirect  = trap_base;
          if (VECTORED_EN && mtvec[1:0] == 2'b01)
            PC_redirect = trap_base + {{(XLEN-8){1'b0}}, irq_cause, 2'b00};
          redirect_mux = 1'b1;
          reg_FD_flush = 1'b1;
          reg_DE_flush = 1'b1;
          reg_EM_flush = 1'b1;
        end
      end
      ST_TRAP, ST_RET: begin
        state_next   = ST_IDLE;
        reg_FD_flush = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  assign trap_busy   = (state_reg != ST_IDLE);
  assign csr_operand = csr_w_imm_mux ? {{(XLEN-5){1'b0}}, csr_w_data_imm} : csr_w_data_reg;
  // An instruction that traps or returns must not commit its CSR write
  assign csr_we      = csr_rw_in && (csr_wsc_mode_in != WSC_NONE) && !trap_take && !mret_take;

  csr_file_px #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) u_csr (
    .clk          (clk),
    .rst          (rst),
    .csr_we       (csr_we),
    .csr_wsc_mode (csr_wsc_mode_in),
    .csr_addr     (csr_rw_addr_in),
    .csr_operand  (csr_operand),
    .csr_r_data   (csr_r_data_out),
    .irq          (irq),
    .trap_take    (trap_take),
    .trap_mepc    (trap_mepc),
    .trap_mcause  (trap_mcause),
    .trap_mtval   (trap_mtval),
    .mret_take    (mret_take),
    .mstatus_mie  (mstatus_mie),
    .mie_bits     (mie_bits),
    .mtvec        (mtvec),
    .mepc         (mepc)
  );

endmodule

// File: tb/tb_exception_unit_px.sv
// Bench for exception_unit_px: directed scenarios plus random traffic, all
// compared against a behavioural trap/CSR model held in the bench.
module tb_exception_unit_px;

  localparam int XLEN    = 32;
  localparam int NUM_IRQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              csr_rw_in, csr_w_imm_mux;
  logic [1:0]        csr_wsc_mode_in;
  logic [11:0]       csr_rw_addr_in;
  logic [XLEN-1:0]   csr_w_data_reg;
  logic [4:0]        csr_w_data_imm;
  logic [XLEN-1:0]   csr_r_data_out;
  logic [NUM_IRQ-1:0] irq;
  logic              illegal_inst, ecall_m, l_access_fault, s_access_fault, mret;
  logic [XLEN-1:0]   epc_cur, epc_next, fault_addr, PC_redirect;
  logic              redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;
  logic              RegWrite_cancel, trap_busy;

  always #5 clk = ~clk;

  exception_unit_px #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .csr_rw_in(csr_rw_in), .csr_wsc_mode_in(csr_wsc_mode_in), .csr_w_imm_mux(csr_w_imm_mux),
    .csr_rw_addr_in(csr_rw_addr_in), .csr_w_data_reg(csr_w_data_reg), .csr_w_data_imm(csr_w_data_imm),
    .csr_r_data_out(csr_r_data_out), .irq(irq),
    .illegal_inst(illegal_inst), .ecall_m(ecall_m), .l_access_fault(l_access_fault),
    .s_access_fault(s_access_fault), .mret(mret),
    .epc_cur(epc_cur), .epc_next(epc_next), .fault_addr(fault_addr),
    .PC_redirect(PC_redirect), .redirect_mux(redirect_mux),
    .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush), .reg_EM_flush(reg_EM_flush),
    .reg_MW_flush(reg_MW_flush), .RegWrite_cancel(RegWrite_cancel), .trap_busy(trap_busy)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model state
  logic              m_mie_b, m_mpie;
  logic [NUM_IRQ-1:0] m_mie;
  logic [31:0]       m_mtvec, m_mepc, m_mcause, m_mtval;
  bit                m_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: m_read = {24'd0, m_mpie, 3'd0, m_mie_b, 3'd0};
      12'h304: m_read = {28'd0, m_mie};
      12'h305: m_read = m_mtvec;
      12'h341: m_read = m_mepc;
      12'h342: m_read = m_mcause;
      12'h343: m_read = m_mtval;
      12'h344: m_read = {28'd0, irq};
      default: m_read = 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie_b = 0; m_mpie = 0; m_mie = '0;
    m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_busy = 0;
  endtask

  task automatic idle_inputs();
    csr_rw_in = 0; csr_wsc_mode_in = 2'b00; csr_w_imm_mux = 0;
    csr_rw_addr_in = 12'h000; csr_w_data_reg = 0; csr_w_data_imm = 0;
    irq = '0; illegal_inst = 0; ecall_m = 0; l_access_fault = 0;
    s_access_fault = 0; mret = 0; epc_cur = 0; epc_next = 0; fault_addr = 0;
  endtask

  task automatic csr_op(input logic [1:0] mode, input logic [11:0] a, input logic [31:0] d);
    csr_rw_in = 1; csr_wsc_mode_in = mode; csr_w_imm_mux = 0;
    csr_rw_addr_in = a; csr_w_data_reg = d;
  endtask

  // Check combinational outputs for the current inputs, clock once, update model.
  task automatic step(input string tag);
    logic [31:0] e_pc, e_rd, base, op, old, nv;
    logic e_mux, e_fd, e_de, e_em, e_mw, e_cancel;
    bit take_exc, take_mret, take_irq;
    int cause, idx;
    #1;
    e_pc = 0; e_mux = 0; e_fd = 0; e_de = 0; e_em = 0; e_mw = 0; e_cancel = 0;
    take_exc = 0; take_mret = 0; take_irq = 0; cause = 0; idx = -1;
    e_rd = m_read(csr_rw_addr_in);
    base = {m_mtvec[31:2], 2'b00};
    if (m_busy) e_fd = 1;
    else begin
      if (illegal_inst)        begin take_exc = 1; cause = 2;  end
      else if (ecall_m)        begin take_exc = 1; cause = 11; end
      else if (l_access_fault) begin take_exc = 1; cause = 5;  end
      else if (s_access_fault) begin take_exc = 1; cause = 7;  end
      if (take_exc) begin
        {e_mux, e_fd, e_de, e_em, e_mw, e_cancel} = 6'b111111;
        e_pc = base;
      end else if (mret) begin
        take_mret = 1; e_mux = 1; e_fd = 1; e_de = 1; e_pc = m_mepc;
      end else if (m_mie_b) begin
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (irq[i] && m_mie[i]) idx = i;
        if (idx >= 0) begin
          take_irq = 1; cause = 16 + idx;
          e_mux = 1; e_fd = 1; e_de = 1; e_em = 1;
          e_pc = base + ((m_mtvec[1:0] == 2'b01) ? 32'(4 * cause) : 32'd0);
        end
      end
    end
    chk({tag, ".pc"}, PC_redirect, e_pc);
    chk({tag, ".mux"}, {31'd0, redirect_mux}, {31'd0, e_mux});
    chk({tag, ".flush"}, {27'd0, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush, RegWrite_cancel},
        {27'd0, e_fd, e_de, e_em, e_mw, e_cancel});
    chk({tag, ".busy"}, {31'd0, trap_busy}, {31'd0, m_busy});
    chk({tag, ".rd"}, csr_r_data_out, e_rd);
    $display("step %-10s pc=%08h mux=%0b fd/de/em/mw/rc=%0b%0b%0b%0b%0b busy=%0b rd=%08h",
             tag, PC_redirect, redirect_mux, reg_FD_flush, reg_DE_flush, reg_EM_flush,
             reg_MW_flush, RegWrite_cancel, trap_busy, csr_r_data_out);
    @(posedge clk);
    if (take_exc || take_irq) begin
      m_mepc   = take_exc ? epc_cur : epc_next;
      m_mcause = take_irq ? (32'h8000_0000 | 32'(cause)) : 32'(cause);
      m_mtval  = (take_exc && (cause == 5 || cause == 7)) ? fault_addr : 32'd0;
      m_mpie   = m_mie_b;
      m_mie_b  = 0;
    end else if (take_mret) begin
      m_mie_b = m_mpie;
      m_mpie  = 1;
    end else if (csr_rw_in && csr_wsc_mode_in != 2'b00) begin
      op  = csr_w_imm_mux ? {27'd0, csr_w_data_imm} : csr_w_data_reg;
      old = m_read(csr_rw_addr_in);
      nv  = (csr_wsc_mode_in == 2'b01) ? op : (csr_wsc_mode_in == 2'b10) ? (old | op) : (old & ~op);
      case (csr_rw_addr_in)
        12'h300: begin m_mie_b = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie   = nv[3:0];
        12'h305: m_mtvec = nv;
        12'h341: m_mepc  = nv;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        default: ;
      endcase
    end
    m_busy = take_exc || take_irq || take_mret;
    @(negedge clk);
  endtask

  task automatic expect_read(input string tag, input logic [11:0] a, input logic [31:0] v);
    idle_inputs();
    csr_rw_addr_in = a;
    #1;
    chk(tag, csr_r_data_out, v);
  endtask

  logic [11:0] addr_tab [9] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342,
                                12'h343, 12'h344, 12'h7C0, 12'h000};

  initial begin
    // Reset state: outputs zero even with events and irq present
    rst = 0;
    idle_inputs();
    model_reset();
    irq = 4'hF; illegal_inst = 1; csr_rw_addr_in = 12'h344;
    #1;
    chk("rst.mux", {31'd0, redirect_mux}, 32'd0);
    chk("rst.pc", PC_redirect, 32'd0);
    chk("rst.fd", {31'd0, reg_FD_flush}, 32'd0);
    chk("rst.rd_mip", csr_r_data_out, 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1;

    // Test 1: illegal beats load fault
    csr_op(2'b01, 12'h305, 32'h800); step("t1.mtvec");
    idle_inputs(); illegal_inst = 1; l_access_fault = 1; epc_cur = 32'h100; fault_addr = 32'hDEAD;
    #1; chk("t1.pc_const", PC_redirect, 32'h800);
    step("t1.trap");
    idle_inputs(); step("t1.busy");
    expect_read("t1.mcause", 12'h342, 32'd2);
    expect_read("t1.mepc", 12'h341, 32'h100);
    expect_read("t1.mtval", 12'h343, 32'd0);

    // Test 2: vectored interrupt, lowest enabled index
    csr_op(2'b01, 12'h305, 32'h801); step("t2.mtvec");
    csr_op(2'b01, 12'h304, 32'h4);   step("t2.mie");
    csr_op(2'b01, 12'h300, 32'h8);   step("t2.mstat");
    idle_inputs(); irq = 4'h6; epc_cur = 32'h500; epc_next = 32'h504;
    #1; chk("t2.pc_const", PC_redirect, 32'h848);
    step("t2.irq");
    idle_inputs(); step("t2.busy");
    expect_read("t2.mcause", 12'h342, 32'h8000_0012);
    expect_read("t2.mepc", 12'h341, 32'h504);

    // Test 3: masked by MIE, then csrrs imm sets MIE
    idle_inputs(); irq = 4'hF; step("t3.masked");
    irq = 4'hF; csr_rw_in = 1; csr_wsc_mode_in = 2'b10; csr_w_imm_mux = 1;
    csr_rw_addr_in = 12'h300; csr_w_data_imm = 5'd8; step("t3.csrrs");
    idle_inputs(); irq = 4'hF;
    #1; chk("t3.take", {31'd0, redirect_mux}, 32'd1);
    step("t3.irq");
    idle_inputs(); step("t3.busy");

    // Test 4: mret restores MIE from MPIE; ecall during RET ignored
    csr_op(2'b01, 12'h341, 32'h204); step("t4.mepc");
    idle_inputs(); mret = 1;
    #1; chk("t4.pc_const", PC_redirect, 32'h204);
    step("t4.mret");
    idle_inputs(); ecall_m = 1; step("t4.ret_ecall");
    expect_read("t4.mstatus", 12'h300, 32'h88);
    expect_read("t4.mcause", 12'h342, 32'h8000_0012);

    // Test 5: trap drops a same-cycle CSR write; unmapped reads zero
    csr_op(2'b01, 12'h342, 32'h55); ecall_m = 1; epc_cur = 32'h300; step("t5.ecall");
    idle_inputs(); step("t5.busy");
    expect_read("t5.mcause", 12'h342, 32'd11);
    csr_op(2'b01, 12'h7C0, 32'hFFFF); step("t5.wr7c0");
    expect_read("t5.rd7c0", 12'h7C0, 32'd0);

    // Test 6: asynchronous reset during TRAP
    idle_inputs(); s_access_fault = 1; epc_cur = 32'h600; fault_addr = 32'h1234; step("t6.trap");
    idle_inputs(); csr_rw_addr_in = 12'h341;
    #2; rst = 0; #1;
    chk("t6.busy", {31'd0, trap_busy}, 32'd0);
    chk("t6.fd", {31'd0, reg_FD_flush}, 32'd0);
    rst = 1; // peek at storage through the read mux before releasing the clock
    #1;
    chk("t6.mepc", csr_r_data_out, 32'd0);
    csr_rw_addr_in = 12'h343; #1;
    chk("t6.mtval", csr_r_data_out, 32'd0);
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs(); step("t6.idle");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      irq             = 4'($urandom);
      illegal_inst    = ($urandom_range(0, 24) == 0);
      ecall_m         = ($urandom_range(0, 24) == 0);
      l_access_fault  = ($urandom_range(0, 19) == 0);
      s_access_fault  = ($urandom_range(0, 19) == 0);
      mret            = ($urandom_range(0, 14) == 0);
      csr_rw_in       = ($urandom_range(0, 2) == 0);
      csr_wsc_mode_in = 2'($urandom);
      csr_w_imm_mux   = 1'($urandom);
      csr_rw_addr_in  = addr_tab[$urandom_range(0, 8)];
      csr_w_data_reg  = $urandom;
      csr_w_data_imm  = 5'($urandom);
      epc_cur         = $urandom;
      epc_next        = $urandom;
      fault_addr      = $urandom;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
